whr_op_sched: RTL and testbench

WHR_OP_SCHED -- requirements
Module: whr_op_sched

---
 rtl/whr_sched_pkg.sv | 24 ++
 rtl/whr_op_sched_if.sv | 27 ++
 rtl/whr_rr_arb.sv | 27 ++
 rtl/whr_op_sched.sv | 121 ++++++++++++
 tb/tb_whr_op_sched.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/whr_sched_pkg.sv
// Shared types and helpers for the output-port scheduler: FSM encoding,
// registered flit-control bundle and the ceil-log2 width function.
package whr_sched_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } sched_state_e;

    typedef struct packed {
        logic vld;
        logic head;
        logic tail;
    } flit_ctl_t;

    // Bits needed to represent 0..value-1; clogb(buffer_size+1) sizes the credit counter.
    function automatic int clogb(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/whr_op_sched_if.sv
// Request/grant/flit-control bundle between the router inputs and one
// output-port scheduler.
interface whr_op_sched_if #(
    parameter int num_ports = 5
);
    logic [num_ports-1:0] req_ip;
    logic [num_ports-1:0] req_head_ip;
    logic [num_ports-1:0] req_tail_ip;
    logic [num_ports-1:0] gnt_ip;
    logic [num_ports-1:0] xbr_ctrl_ip;
    logic                 flit_valid;
    logic                 flit_head;
    logic                 flit_tail;
    logic                 flow_ctrl_in;
    logic                 full;
    logic                 error;

    modport master (
        output req_ip, req_head_ip, req_tail_ip, flow_ctrl_in,
        input  gnt_ip, xbr_ctrl_ip, flit_valid, flit_head, flit_tail, full, error
    );

    modport slave (
        input  req_ip, req_head_ip, req_tail_ip, flow_ctrl_in,
        output gnt_ip, xbr_ctrl_ip, flit_valid, flit_head, flit_tail, full, error
    );
endinterface

// File: rtl/whr_rr_arb.sv
// Combinational round-robin arbiter: the lowest requesting index at or after
// the pointer (wrapping) wins; gnt is one-hot or zero.
module whr_rr_arb #(
    parameter int n  = 5,
    parameter int pw = 3
) (
    input  logic [n-1:0]  req,
    input  logic [pw-1:0] pointer,
    output logic [n-1:0]  gnt
);

    always_comb begin
        logic found;
        int   idx;
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < n; i++) begin
            idx = (int'(pointer) + i) % n;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/whr_op_sched.sv
// Wormhole output-port scheduler: round-robin head arbitration, packet lock
// until tail, credit-based flow control and a one-cycle registered xbar stage.
module whr_op_sched
    import whr_sched_pkg::*;
#(
    parameter int num_ports   = 5,
    parameter int buffer_size = 8
) (
    input logic           clk,
    input logic           reset,
    whr_op_sched_if.slave bus
);

    localparam int            CW       = clogb(buffer_size + 1);
    localparam int            PW       = (num_ports > 1) ? clogb(num_ports) : 1;
    localparam logic [CW-1:0] CRED_MAX = CW'(buffer_size);
    localparam logic [PW-1:0] LAST_IP  = PW'(num_ports - 1);

    sched_state_e         state;
    logic [PW-1:0]        owner;
    logic [PW-1:0]        pointer;
    logic [CW-1:0]        credits;
    logic [num_ports-1:0] xbr_q;
    flit_ctl_t            flit_q;
    logic                 error_q;

    logic [num_ports-1:0] elig;
    logic [num_ports-1:0] arb_gnt;
    logic [num_ports-1:0] gnt;
    logic [PW-1:0]        winner;
    logic                 granted;
    logic                 win_head;
    logic                 win_tail;
    logic                 has_credit;
    logic                 err_nxt;

    assign has_credit = (credits != '0);
    assign elig       = bus.req_ip & bus.req_head_ip;

    whr_rr_arb #(
        .n  (num_ports),
        .pw (PW)
    ) u_arb (
        .req     (elig),
        .pointer (pointer),
        .gnt     (arb_gnt)
    );

    // Grant is suppressed during reset so a held request cannot dequeue a flit.
    always_comb begin
        gnt = '0;
        if (reset && has_credit) begin
            if (state == ST_IDLE) gnt = arb_gnt;
            else                  gnt[owner] = bus.req_ip[owner];
        end
    end

    always_comb begin
        winner = '0;
        for (int i = 0; i < num_ports; i++)
            if (gnt[i]) winner = PW'(i);
    end

    assign granted  = |gnt;
    assign win_head = |(gnt & bus.req_head_ip);
    assign win_tail = |(gnt & bus.req_tail_ip);

    // Protocol violations: credit overflow, body flit with no owner, or a new
    // head from the input that already owns the port.
    always_comb begin
        err_nxt = bus.flow_ctrl_in && !granted && (credits == CRED_MAX);
        if (state == ST_IDLE) err_nxt = err_nxt | (|(bus.req_ip & ~bus.req_head_ip));
        else                  err_nxt = err_nxt | (bus.req_ip[owner] & bus.req_head_ip[owner]);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_IDLE;
            owner   <= '0;
            pointer <= '0;
            credits <= CRED_MAX;
            xbr_q   <= '0;
            flit_q  <= '0;
            error_q <= 1'b0;
        end else begin
            xbr_q   <= gnt;
            flit_q  <= '{vld: granted, head: win_head, tail: win_tail};
            error_q <= err_nxt;

            case (state)
                ST_IDLE: begin
                    if (granted) begin
                        pointer <= (winner == LAST_IP) ? '0 : winner + PW'(1);
                        // Single-flit packets never take the lock.
                        if (!win_tail) begin
                            state <= ST_LOCKED;
                            owner <= winner;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (granted && win_tail) state <= ST_IDLE;
                end
            endcase

            if (granted && !bus.flow_ctrl_in)
                credits <= credits - CW'(1);
            else if (!granted && bus.flow_ctrl_in && (credits != CRED_MAX))
                credits <= credits + CW'(1);
        end
    end

    assign bus.gnt_ip      = gnt;
    assign bus.xbr_ctrl_ip = xbr_q;
    assign bus.flit_valid  = flit_q.vld;
    assign bus.flit_head   = flit_q.head;
    assign bus.flit_tail   = flit_q.tail;
    assign bus.full        = ~has_credit;
    assign bus.error       = error_q;

endmodule

// File: tb/tb_whr_op_sched.sv
// Directed-vector bench for whr_op_sched: arbitration, packet lock, credits,
// error pulses and mid-packet reset, all against hand-computed values.
module tb_whr_op_sched;

    localparam int NP = 5;
    localparam int BS = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_vec = 0;
    int   n_mis = 0;
    int   n_gnt;

    always #5 clk = ~clk;

    whr_op_sched_if #(.num_ports(NP)) bus ();

    whr_op_sched #(
        .num_ports   (NP),
        .buffer_size (BS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [NP-1:0] r, input logic [NP-1:0] h,
                         input logic [NP-1:0] t, input logic f);
        bus.req_ip       = r;
        bus.req_head_ip  = h;
        bus.req_tail_ip  = t;
        bus.flow_ctrl_in = f;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive('0, '0, '0, 1'b0);
        cyc();
        cyc();
        reset = 1'b1;
    endtask

    // Offer single-flit packets on input 0 for 10 cycles, no credit returns.
    task automatic drain(output int n);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            drive(5'b00001, 5'b00001, 5'b00001, 1'b0);
            if (bus.gnt_ip[0]) n++;
            cyc();
        end
        drive('0, '0, '0, 1'b0);
    endtask

    initial begin
        // reset state, with a request held during reset
        drive(5'b00001, 5'b00001, 5'b00001, 1'b0);
        chk("rst_gnt_comb", bus.gnt_ip, 5'b00000);
        cyc();
        cyc();
        chk("rst_gnt", bus.gnt_ip, 5'b00000);
        chk("rst_full", bus.full, 1'b0);
        chk("rst_error", bus.error, 1'b0);
        chk("rst_fvalid", {bus.flit_valid, bus.flit_head, bus.flit_tail}, 3'b000);
        chk("rst_xbr", bus.xbr_ctrl_ip, 5'b00000);
        drive('0, '0, '0, 1'b0);
        reset = 1'b1;

        // single-flit packet from input 2
        drive(5'b00100, 5'b00100, 5'b00100, 1'b0);
        chk("sf_gnt", bus.gnt_ip, 5'b00100);
        cyc();
        chk("sf_flit", {bus.flit_valid, bus.flit_head, bus.flit_tail}, 3'b111);
        chk("sf_xbr", bus.xbr_ctrl_ip, 5'b00100);
        chk("sf_err", bus.error, 1'b0);
        // still IDLE: a different input's head is granted immediately
        drive(5'b00001, 5'b00001, 5'b00001, 1'b0);
        chk("sf_idle_gnt", bus.gnt_ip, 5'b00001);
        cyc();
        drive('0, '0, '0, 1'b0);
        cyc();

        // 3-flit packet on input 1 while input 3 keeps requesting a head
        do_reset();
        drive(5'b01010, 5'b01010, 5'b00000, 1'b0);
        chk("pk_g1", bus.gnt_ip, 5'b00010);
        cyc();
        drive(5'b01010, 5'b01000, 5'b00000, 1'b0);
        chk("pk_g2", bus.gnt_ip, 5'b00010);
        cyc();
        chk("pk_err", bus.error, 1'b0);
        chk("pk_fhead2", bus.flit_head, 1'b0);
        drive(5'b01010, 5'b01000, 5'b00010, 1'b0);
        chk("pk_g3", bus.gnt_ip, 5'b00010);
        cyc();
        drive(5'b01000, 5'b01000, 5'b00000, 1'b0);
        chk("pk_g4", bus.gnt_ip, 5'b01000);
        chk("pk_ftail", bus.flit_tail, 1'b1);
        chk("pk_xbr", bus.xbr_ctrl_ip, 5'b00010);
        cyc();
        // input 3 now owns the port; a second head from it is a violation
        drive(5'b01000, 5'b01000, 5'b00000, 1'b0);
        chk("lk_head_gnt", bus.gnt_ip, 5'b01000);
        cyc();
        chk("lk_head_err", bus.error, 1'b1);
        drive('0, '0, '0, 1'b0);
        cyc();
        chk("lk_err_clr", bus.error, 1'b0);

        // credit exhaustion and a single credit return
        do_reset();
        for (int i = 0; i < BS; i++) begin
            drive(5'b00001, 5'b00001, 5'b00001, 1'b0);
            chk($sformatf("cr_g%0d", i), bus.gnt_ip, 5'b00001);
            cyc();
        end
        chk("cr_full", bus.full, 1'b1);
        drive(5'b00001, 5'b00001, 5'b00001, 1'b0);
        chk("cr_no9", bus.gnt_ip, 5'b00000);
        cyc();
        drive(5'b00001, 5'b00001, 5'b00001, 1'b1);
        chk("cr_ret_nog", bus.gnt_ip, 5'b00000);
        cyc();
        chk("cr_notfull", bus.full, 1'b0);
        chk("cr_ret_err", bus.error, 1'b0);
        drive(5'b00001, 5'b00001, 5'b00001, 1'b0);
        chk("cr_one_more", bus.gnt_ip, 5'b00001);
        cyc();
        chk("cr_full2", bus.full, 1'b1);
        drive(5'b00001, 5'b00001, 5'b00001, 1'b0);
        chk("cr_stop", bus.gnt_ip, 5'b00000);
        cyc();
        drive('0, '0, '0, 1'b0);

        // all inputs requesting, credits refilled every cycle
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(5'b11111, 5'b11111, 5'b11111, 1'b1);
            chk($sformatf("rr_g%0d", i), bus.gnt_ip, 5'b00001 << (i % NP));
            cyc();
            chk($sformatf("rr_err%0d", i), bus.error, 1'b0);
        end
        drive('0, '0, '0, 1'b0);

        // credit overflow
        do_reset();
        drive('0, '0, '0, 1'b1);
        cyc();
        chk("ov_err", bus.error, 1'b1);
        drive('0, '0, '0, 1'b0);
        cyc();
        chk("ov_err_clr", bus.error, 1'b0);
        drain(n_gnt);
        chk("ov_credits", n_gnt, BS);

        // body flit with no owner
        do_reset();
        drive(5'b00010, 5'b00000, 5'b00000, 1'b0);
        chk("bd_gnt", bus.gnt_ip, 5'b00000);
        cyc();
        chk("bd_err", bus.error, 1'b1);
        chk("bd_fvalid", bus.flit_valid, 1'b0);
        drive('0, '0, '0, 1'b0);
        cyc();
        chk("bd_err_clr", bus.error, 1'b0);

        // reset after 2 of 4 flits from input 2
        do_reset();
        drive(5'b00100, 5'b00100, 5'b00000, 1'b0);
        chk("mr_g1", bus.gnt_ip, 5'b00100);
        cyc();
        drive(5'b00100, 5'b00000, 5'b00000, 1'b0);
        chk("mr_g2", bus.gnt_ip, 5'b00100);
        cyc();
        reset = 1'b0;
        #1;
        chk("mr_rst_gnt", bus.gnt_ip, 5'b00000);
        cyc();
        chk("mr_rst_err", bus.error, 1'b0);
        chk("mr_rst_fv", bus.flit_valid, 1'b0);
        reset = 1'b1;
        drive(5'b10000, 5'b10000, 5'b10000, 1'b0);
        chk("mr_new_gnt", bus.gnt_ip, 5'b10000);
        cyc();
        chk("mr_new_err", bus.error, 1'b0);
        drain(n_gnt);
        chk("mr_credits", n_gnt, BS - 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
